fastica_update_accum: RTL and testbench

FASTICA_UPDATE_ACCUM -- requirements
Module: fastica_update_accum

---
 rtl/fastica_update_accum_pkg.sv | 31 +++
 rtl/fastica_mac_lane.sv | 62 ++++++
 rtl/fastica_update_accum.sv | 129 ++++++++++++
 tb/tb_fastica_update_accum.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fastica_update_accum_pkg.sv
// Shared definitions for the FastICA datapath: control states, accumulator
// sizing and the signed saturation helper used by cuber, accumulator and normaliser.
package fastica_update_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam int SAT_W = 64;

  // Product of two data words plus one bit of growth per doubling of the batch.
  function automatic int acc_width(input int data_width, input int log2_samples);
    return 2 * data_width + log2_samples;
  endfunction

  // Clamp a sign-extended value to the range of a dw-bit signed word.
  function automatic logic signed [SAT_W-1:0] sat_dw(input logic signed [SAT_W-1:0] v,
                                                     input int dw);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fastica_mac_lane.sv
// One vector element: accumulates x*g over a batch, then forms
// w_new = sat(sat(mean) - 3*w) in a single registered step.
module fastica_mac_lane
  import fastica_update_accum_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_WIDTH   = 10,
  parameter int LOG2_SAMPLES = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         acc_en,
  input  logic                         final_en,
  input  logic signed [DATA_WIDTH-1:0] w_i,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  input  logic signed [DATA_WIDTH-1:0] cube_i,
  output logic signed [DATA_WIDTH-1:0] w_new_o
);

  localparam int ACC_W = acc_width(DATA_WIDTH, LOG2_SAMPLES);
  localparam int SHIFT = FRAC_WIDTH + LOG2_SAMPLES;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]        acc_q, acc_d, acc_shr;
  logic signed [DATA_WIDTH-1:0]   mean;
  logic signed [DATA_WIDTH+1:0]   three_w;
  logic signed [DATA_WIDTH+2:0]   diff;
  logic signed [DATA_WIDTH-1:0]   w_new_q, w_new_d;

  always_comb begin
    prod  = x_i * cube_i;
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
    // Dividing by the sample count and removing the extra fraction in one shift.
    acc_shr = acc_q >>> SHIFT;
    mean    = DATA_WIDTH'(sat_dw(SAT_W'(acc_shr), DATA_WIDTH));
    three_w = ((DATA_WIDTH+2)'(w_i) <<< 1) + (DATA_WIDTH+2)'(w_i);
    diff    = (DATA_WIDTH+3)'(mean) - (DATA_WIDTH+3)'(three_w);
    w_new_d = w_new_q;
    if (final_en) begin
      w_new_d = DATA_WIDTH'(sat_dw(SAT_W'(diff), DATA_WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      w_new_q <= '0;
    end else begin
      acc_q   <= acc_d;
      w_new_q <= w_new_d;
    end
  end

  assign w_new_o = w_new_q;

endmodule

// File: rtl/fastica_update_accum.sv
// FastICA weight update: averages x*g over a batch of samples in N_DIM lanes,
// subtracts 3*w and streams the new weight vector out one element per handshake.
module fastica_update_accum
  import fastica_update_accum_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_WIDTH   = 10,
  parameter int N_DIM        = 4,
  parameter int LOG2_SAMPLES = 8,
  localparam int IDX_W       = (N_DIM > 1) ? $clog2(N_DIM) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [N_DIM*DATA_WIDTH-1:0] w_in,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       cube_in,
  input  logic [N_DIM*DATA_WIDTH-1:0] x_in,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int CNT_W = (LOG2_SAMPLES > 0) ? LOG2_SAMPLES : 1;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [N_DIM*DATA_WIDTH-1:0] w_q, w_d;
  logic                        out_valid_q, out_valid_d;
  logic                        clear, acc_en, final_en;
  logic                        hs, last_sample, last_elem;
  logic signed [DATA_WIDTH-1:0] w_new [N_DIM];

  assign hs          = out_valid_q & out_ready;
  assign last_sample = (cnt_q == CNT_W'((1 << LOG2_SAMPLES) - 1));
  assign last_elem   = (idx_q == IDX_W'(N_DIM - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    w_d         = w_q;
    out_valid_d = out_valid_q;
    clear       = 1'b0;
    acc_en      = 1'b0;
    final_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          w_d     = w_in;
          cnt_d   = '0;
          clear   = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_en = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (last_sample) state_d = FINAL;
        end
      end
      FINAL: begin
        final_en = 1'b1;
        idx_d    = '0;
        state_d  = OUT;
      end
      OUT: begin
        // out_valid trails entry to OUT by one cycle, giving the 2-cycle latency.
        out_valid_d = 1'b1;
        if (hs) begin
          if (last_elem) begin
            out_valid_d = 1'b0;
            idx_d       = '0;
            state_d     = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      w_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      w_q         <= w_d;
      out_valid_q <= out_valid_d;
    end
  end

  for (genvar i = 0; i < N_DIM; i++) begin : g_lane
    fastica_mac_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .FRAC_WIDTH  (FRAC_WIDTH),
      .LOG2_SAMPLES(LOG2_SAMPLES)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .acc_en  (acc_en),
      .final_en(final_en),
      .w_i     (w_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .x_i     (x_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .cube_i  (cube_in),
      .w_new_o (w_new[i])
    );
  end

  assign out_valid = out_valid_q;
  assign out_idx   = idx_q;
  assign out_data  = out_valid_q ? w_new[idx_q] : '0;
  assign busy      = (state_q != IDLE);
  assign done      = hs & last_elem;

endmodule

// File: tb/tb_fastica_update_accum.sv
// Scoreboard bench for fastica_update_accum: driver pushes expected elements,
// a negedge monitor pops and compares on every output handshake.
module tb_fastica_update_accum;

  localparam int DW  = 16;
  localparam int FW  = 10;
  localparam int ND  = 4;
  localparam int L2S = 2;
  localparam int NS  = 1 << L2S;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, out_ready;
  logic [ND*DW-1:0] w_in, x_in;
  logic [DW-1:0] cube_in, out_data;
  logic [1:0]    out_idx;
  logic          out_valid, busy, done;

  fastica_update_accum #(
    .DATA_WIDTH(DW), .FRAC_WIDTH(FW), .N_DIM(ND), .LOG2_SAMPLES(L2S)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .w_in(w_in), .in_valid(in_valid),
    .cube_in(cube_in), .x_in(x_in), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_idx(out_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_data_q[$];
  int exp_idx_q[$];
  int bw[ND];
  int bx[NS][ND];
  int bc[NS];
  bit lat_armed = 1'b0;
  int last_edge = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint satw(input longint v);
    longint hi, lo;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference: mean of x[i]*g over the batch in real fixed-point terms, minus 3w.
  task automatic push_model();
    longint acc, mean;
    for (int i = 0; i < ND; i++) begin
      acc = 0;
      for (int s = 0; s < NS; s++) acc += longint'(bx[s][i]) * longint'(bc[s]);
      mean = satw(acc >>> (FW + L2S));
      exp_data_q.push_back(int'(satw(mean - 3 * longint'(bw[i]))));
      exp_idx_q.push_back(i);
    end
  endtask

  task automatic push_const(input int a, input int b, input int c, input int d);
    exp_data_q.push_back(a); exp_idx_q.push_back(0);
    exp_data_q.push_back(b); exp_idx_q.push_back(1);
    exp_data_q.push_back(c); exp_idx_q.push_back(2);
    exp_data_q.push_back(d); exp_idx_q.push_back(3);
  endtask

  task automatic set_nominal();
    bw = '{1024, 0, 0, 0};
    for (int s = 0; s < NS; s++) begin
      bx[s] = '{1024, 1024, 0, 0};
      bc[s] = 1024;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sample(input int s);
    for (int i = 0; i < ND; i++) x_in[i*DW +: DW] = DW'(bx[s][i]);
    cube_in  = DW'(bc[s]);
    in_valid = 1'b1;
  endtask

  task automatic drain(input bit bp);
    int stall;
    stall = 0;
    for (int c = 0; c < 60; c++) begin
      if (!busy) begin
        out_ready = 1'b1;
        return;
      end
      if (bp && out_valid && out_idx == 2'd1 && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      tick();
    end
    check(1'b0, "drain_timeout", busy, 0);
    out_ready = 1'b1;
  endtask

  task automatic run_batch(input bit gaps, input bit idle_noise, input bit restart,
                           input bit bp, input bit use_model);
    if (idle_noise) begin
      for (int k = 0; k < 3; k++) begin
        x_in = {$urandom, $urandom}; cube_in = DW'($urandom); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
      end
    end
    for (int i = 0; i < ND; i++) w_in[i*DW +: DW] = DW'(bw[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    w_in  = {$urandom, $urandom};
    check(busy == 1'b1, "busy_after_start", busy, 1);
    for (int s = 0; s < NS; s++) begin
      if (gaps) repeat ($urandom_range(1, 3)) tick();
      if (restart && s == 1) start = 1'b1;
      drive_sample(s);
      if (s == NS - 1 && use_model) push_model();
      tick();
      in_valid = 1'b0;
      start    = 1'b0;
      x_in     = {$urandom, $urandom};
      if (s == NS - 1) begin
        last_edge = cyc;
        lat_armed = 1'b1;
      end
    end
    drain(bp);
  endtask

  // Monitor: compares every accepted element against the scoreboard.
  initial begin
    bit prev_valid, prev_ready;
    logic [DW-1:0] prev_data;
    logic [1:0] prev_idx;
    int ed, ei;
    prev_valid = 1'b0; prev_ready = 1'b1; prev_data = '0; prev_idx = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid && !prev_valid && lat_armed) begin
          check(cyc - last_edge == 2, "latency", cyc - last_edge, 2);
          lat_armed = 1'b0;
        end
        if (prev_valid && !prev_ready) begin
          check(out_valid == 1'b1, "hold_valid", out_valid, 1);
          check(out_data == prev_data, "hold_data", $signed(out_data), $signed(prev_data));
          check(out_idx == prev_idx, "hold_idx", out_idx, prev_idx);
        end
        if (out_valid && out_ready) begin
          if (exp_data_q.size() == 0) begin
            check(1'b0, "unexpected_output", $signed(out_data), -1);
          end else begin
            ed = exp_data_q.pop_front();
            ei = exp_idx_q.pop_front();
            check(int'($signed(out_data)) == ed, "out_data", $signed(out_data), ed);
            check(int'(out_idx) == ei, "out_idx", out_idx, ei);
            check(done == (ei == ND - 1), "done_on_hs", done, ei == ND - 1);
          end
        end else begin
          check(done == 1'b0, "done_idle", done, 0);
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_idx   = out_idx;
    end
  end

  task automatic check_zero_outputs(input string tag);
    check(out_valid == 1'b0, {tag, "_out_valid"}, out_valid, 0);
    check(busy == 1'b0, {tag, "_busy"}, busy, 0);
    check(done == 1'b0, {tag, "_done"}, done, 0);
    check(out_data == '0, {tag, "_out_data"}, out_data, 0);
    check(out_idx == '0, {tag, "_out_idx"}, out_idx, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    w_in = '0; x_in = '0; cube_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    set_nominal();
    push_const(-2048, 1024, 0, 0);
    run_batch(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    bw = '{-16384, 16384, 0, 0};
    for (int s = 0; s < NS; s++) begin
      bx[s] = '{32767, -32768, 0, 0};
      bc[s] = 32767;
    end
    push_const(32767, -32768, 0, 0);
    run_batch(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    set_nominal();
    push_const(-2048, 1024, 0, 0);
    run_batch(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    set_nominal();
    push_const(-2048, 1024, 0, 0);
    run_batch(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Abort a batch after two samples; nothing from it may appear.
    set_nominal();
    for (int i = 0; i < ND; i++) w_in[i*DW +: DW] = DW'(bw[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 2; s++) begin
      drive_sample(s);
      tick();
      in_valid = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_zero_outputs("midreset");
    end
    rst_n = 1'b1;
    push_const(-2048, 1024, 0, 0);
    run_batch(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < ND; i++) bw[i] = int'($urandom_range(0, 40000)) - 20000;
      for (int s = 0; s < NS; s++) begin
        for (int i = 0; i < ND; i++)
          bx[s][i] = (k % 2 == 0) ? int'($urandom_range(0, 4095)) - 2048
                                  : int'($urandom_range(0, 65535)) - 32768;
        bc[s] = int'($urandom_range(0, 65535)) - 32768;
      end
      run_batch(k[0], 1'b0, 1'b0, k == 3, 1'b1);
    end

    repeat (5) tick();
    check(exp_data_q.size() == 0, "leftover_expected", exp_data_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected 0", 1);
    $fatal(1, "timeout");
  end

endmodule
